// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter held in a bank of JK stages.
// J/K excitation is derived from the current count and exported.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic             LOAD_ERR,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K
);

  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MOD_X = W1'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic             err_r;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic             d_ok;
  logic             at_last;
  logic             at_zero;

  assign at_last = (q_r == LAST);
  assign at_zero = (q_r == '0);

  // compare one bit wider so MODULUS == 2**WIDTH is representable
  assign d_ok = ({1'b0, D} < MOD_X);

  always_comb begin
    nxt = q_r;
    if (UP) begin
      nxt = at_last ? '0 : q_r + 1'b1;
    end else begin
      nxt = at_zero ? LAST : q_r - 1'b1;
    end
  end

  always_comb begin
    j_c = '0;
    k_c = '0;
    if (!RST) begin
      k_c = '1;
    end else if (LOAD) begin
      if (d_ok) begin
        j_c = D;
        k_c = ~D;
      end else begin
        k_c = '1;
      end
    end else if (EN) begin
      // toggle only the bits that differ
      j_c = q_r ^ nxt;
      k_c = q_r ^ nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= (j_c & ~q_r) | (~k_c & q_r);
      err_r <= LOAD & ~d_ok;
    end
  end

  assign Q        = q_r;
  assign Qbar     = ~q_r;
  assign LOAD_ERR = err_r;
  assign J        = j_c;
  assign K        = k_c;
  assign TC       = RST & ~LOAD & EN & (UP ? at_last : at_zero);

endmodule
